// File: rtl/decoder_pkg.sv
// Shared encodings for the one-hot decoder / scan sequencer.
package decoder_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } dec_state_t;

endpackage

// File: rtl/onehot_dec.sv
// Combinational SEL_W-to-2^SEL_W one-hot decoder with enable.
// The output is all-zero when en is low.
module onehot_dec #(
  parameter  int SEL_W = 4,
  localparam int OUT_N = 1 << SEL_W
) (
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_N-1:0] y
);

  // Set exactly one bit when enabled.
  always_comb begin
    // NOTE: assigning a default before any conditional assignment keeps
    // combinational logic from inferring a latch.
    y = '0;
    if (en) begin
      y[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/decoder_scan_nx.sv
// N-to-2^N one-hot decoder with registered outputs and an auto-scan
// sequencer. DIRECT decodes a with one cycle of latency; SCAN steps a
// one-hot line through all outputs, holding each for dwell+1 cycles.
module decoder_scan_nx
  import decoder_pkg::*;
#(
  parameter  int SEL_W   = 4,
  parameter  int DWELL_W = 8,
  localparam int OUT_N   = 1 << SEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [SEL_W-1:0]   a,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_N-1:0]   y,
  output logic [SEL_W-1:0]   idx,
  output logic               valid,
  output logic               wrap
);

  dec_state_t         state;
  dec_state_t         state_nxt;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] cnt_nxt;
  logic [SEL_W-1:0]   idx_nxt;
  logic               wrap_nxt;
  logic               active_nxt;
  logic [OUT_N-1:0]   y_nxt;

  // Next state, next index, dwell counter and wrap flag.
  always_comb begin
    state_nxt = IDLE;
    idx_nxt   = idx;
    cnt_nxt   = '0;
    wrap_nxt  = 1'b0;

    if (en) begin
      state_nxt = (mode == MODE_SCAN) ? SCAN : DIRECT;
    end

    unique case (state_nxt)
      DIRECT: begin
        idx_nxt = a;
      end
      SCAN: begin
        if (state != SCAN) begin
          // Scan always restarts from a; no position is resumed.
          idx_nxt = a;
          cnt_nxt = dwell;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - DWELL_W'(1);
        end else begin
          idx_nxt  = idx + SEL_W'(1);
          cnt_nxt  = dwell;
          wrap_nxt = &idx;
        end
      end
      default: begin
        // IDLE: idx keeps its last value, counter is cleared.
      end
    endcase
  end

  assign active_nxt = (state_nxt != IDLE);

  // y is decoded from the next index so it lines up with idx and valid.
  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .en  (active_nxt),
    .sel (idx_nxt),
    .y   (y_nxt)
  );

  // FSM and output registers; reset dominates every other input.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      y     <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      y     <= y_nxt;
      valid <= active_nxt;
      wrap  <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_decoder_scan_nx.sv
// Self-checking bench: directed cases plus randomized stimulus, compared
// every cycle against a behavioural model for SEL_W=4 and SEL_W=3.
module tb_decoder_scan_nx;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        mode;
  logic [3:0]  a;
  logic [7:0]  dwell;

  logic [15:0] y4;
  logic [3:0]  idx4;
  logic        valid4, wrap4;
  logic [7:0]  y3;
  logic [2:0]  idx3;
  logic        valid3, wrap3;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state per instance: [0] = 16 lines, [1] = 8 lines.
  bit m_act [2];
  bit m_scan[2];
  int m_idx [2];
  int m_hold[2];
  bit m_wrap[2];

  always #5 clk = ~clk;

  decoder_scan_nx #(.SEL_W(4), .DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .dwell(dwell),
    .y(y4), .idx(idx4), .valid(valid4), .wrap(wrap4)
  );

  decoder_scan_nx #(.SEL_W(3), .DWELL_W(8)) dut3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a[2:0]), .dwell(dwell),
    .y(y3), .idx(idx3), .valid(valid3), .wrap(wrap3)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // One clock of the reference behaviour for a decoder with nlines outputs.
  task automatic model_step(input int k, input int nlines);
    int sel;
    sel = int'(a) % nlines;
    m_wrap[k] = 1'b0;
    if (rst) begin
      m_act[k] = 0; m_scan[k] = 0; m_idx[k] = 0; m_hold[k] = 0;
    end else if (!en) begin
      m_act[k] = 0; m_scan[k] = 0;
    end else if (!mode) begin
      m_act[k] = 1; m_scan[k] = 0; m_idx[k] = sel;
    end else if (!m_scan[k]) begin
      m_act[k] = 1; m_scan[k] = 1; m_idx[k] = sel; m_hold[k] = int'(dwell);
    end else if (m_hold[k] > 0) begin
      m_hold[k]--;
    end else begin
      m_idx[k]  = (m_idx[k] + 1) % nlines;
      m_wrap[k] = (m_idx[k] == 0);
      m_hold[k] = int'(dwell);
    end
  endtask

  function automatic logic [31:0] exp_y(input int k);
    return m_act[k] ? (32'd1 << m_idx[k]) : 32'd0;
  endfunction

  // Advance one edge, update the model, then compare both instances.
  task automatic cycle();
    @(posedge clk);
    model_step(0, 16);
    model_step(1, 8);
    #1;
    check("y4",     {16'd0, y4},     exp_y(0));
    check("idx4",   {28'd0, idx4},   32'(m_idx[0]));
    check("valid4", {31'd0, valid4}, {31'd0, m_act[0]});
    check("wrap4",  {31'd0, wrap4},  {31'd0, m_wrap[0]});
    check("y3",     {24'd0, y3},     exp_y(1));
    check("idx3",   {29'd0, idx3},   32'(m_idx[1]));
    check("valid3", {31'd0, valid3}, {31'd0, m_act[1]});
    check("wrap3",  {31'd0, wrap3},  {31'd0, m_wrap[1]});
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; mode = 1'b1; a = 4'd0; dwell = 8'd0;

    // Reset held two cycles while enabled in SCAN.
    cycle(); cycle();
    check("rst_y", {16'd0, y4}, 32'h0);
    check("rst_valid", {31'd0, valid4}, 32'h0);

    rst = 1'b0; a = 4'd3;
    cycle();
    check("post_rst_y", {16'd0, y4}, 32'h0008);

    // Direct sweep.
    mode = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a = 4'(i);
      cycle();
      check("direct_y", {16'd0, y4}, 32'd1 << i);
    end

    // Scan wrap with dwell=0 from a=14 (a=6 on the 8-line instance).
    mode = 1'b1; a = 4'd14; dwell = 8'd0;
    cycle(); check("scan_y0", {16'd0, y4}, 32'h4000);
    cycle(); check("scan_y1", {16'd0, y4}, 32'h8000);
    cycle(); check("scan_y2", {16'd0, y4}, 32'h0001);
    check("scan_wrap", {31'd0, wrap4}, 32'h1);
    for (int i = 0; i < 36; i++) cycle();

    // Scan with dwell=2 from a=0, dwell shortened mid-hold.
    en = 1'b0; cycle();
    en = 1'b1; a = 4'd0; dwell = 8'd2;
    for (int i = 0; i < 4; i++) cycle();
    dwell = 8'd0;
    for (int i = 0; i < 10; i++) cycle();

    // en dropped on the cycle a wrap is due.
    en = 1'b0; cycle();
    en = 1'b1; a = 4'd14; dwell = 8'd0;
    cycle(); cycle();
    en = 1'b0; cycle();
    check("drop_y", {16'd0, y4}, 32'h0);
    check("drop_wrap", {31'd0, wrap4}, 32'h0);
    en = 1'b1; mode = 1'b1; a = 4'd7;
    cycle(); check("reen_y", {16'd0, y4}, 32'h0080);
    cycle(); cycle();

    // SCAN -> DIRECT switch.
    mode = 1'b0; a = 4'd9;
    cycle(); check("sw_y", {16'd0, y4}, 32'h0200);

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      en    = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      a     = 4'($urandom);
      if ($urandom_range(0, 7) == 0) dwell = 8'($urandom_range(0, 3));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
